calc_operand_sequencer: RTL and testbench
=========================================

# calc_operand_sequencer

Controller that sequences two-operand entry for the calculator datapath. It takes decoded keypad events and assembles a two-digit BCD value on `bcd_out`. It pulses `load_a` and `load_b` to capture that value into the operand register pair, then starts the arithmetic unit and waits for it to complete. It sits between the keypad decoder and the operand registers / arithmetic unit, and drives the display-source select.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles in WAIT_DONE before an error is declared; must be ≥1.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low
- `key_valid`  in  1  one-cycle pulse, `key_code` valid
- `key_code`  in  4  0x0–0x9 digit; 0xA ENTER; 0xB CLEAR; 0xC–0xF ignored
- `op_done`  in  1  arithmetic unit completion pulse
- `bcd_out`  out  8  operand being entered, {tens, ones} BCD; feeds operand registers
- `digit_cnt`  out  2  digits entered for current operand, saturates at 2
- `load_a`  out  1  one-cycle capture strobe, operand A
- `load_b`  out  1  one-cycle capture strobe, operand B
- `op_start`  out  1  one-cycle start strobe to arithmetic unit
- `busy`  out  1  high in START and WAIT_DONE
- `disp_result`  out  1  high in SHOW; display shows result instead of `bcd_out`
- `error`  out  1  high in SHOW when entered by timeout

## Operation
- States:
  - ENTER_A: digit → ENTER_A; ENTER → LOAD_A.
  - LOAD_A: → ENTER_B, unconditional.
  - ENTER_B: digit → ENTER_B; ENTER → LOAD_B.
  - LOAD_B: → START.
  - START: → WAIT_DONE.
  - WAIT_DONE: `op_done` → SHOW with `error`=0; timeout → SHOW with `error`=1.
  - SHOW: ENTER → ENTER_A.
- Digit entry, ENTER_A/ENTER_B only:
  - `bcd_out` ← {`bcd_out[3:0]`, `key_code`}. A third or later digit drops the oldest; only the last two digits are kept.
  - `digit_cnt` increments, saturating at 2.
- ENTER with `digit_cnt`=0 is legal and loads 0x00.
- Key handling:
  - Digit keys outside ENTER_A/ENTER_B are ignored.
  - Codes 0xC–0xF are ignored in every state.
  - CLEAR (0xB) in any state → ENTER_A; `bcd_out`, `digit_cnt`, `error` cleared; no strobe issued.
  - CLEAR takes priority over the state's own transition, including LOAD_A/LOAD_B/START. A strobe already asserted in the current cycle completes; nothing further is issued.
- Strobes are Moore outputs: `load_a`=1 exactly in LOAD_A, `load_b` in LOAD_B, `op_start` in START.
- `bcd_out` is held stable through LOAD_A/LOAD_B so the register samples the final value.
- On leaving LOAD_A or LOAD_B, `bcd_out` and `digit_cnt` clear to 0.
- Leaving SHOW clears `bcd_out`, `digit_cnt`, `error`.
- Timeout counter:
  - Clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - Expiry when count reaches `TIMEOUT_CYCLES`−1 without `op_done`.
  - `op_done` in the same cycle as expiry: done wins, `error`=0.
- `op_done` outside WAIT_DONE is ignored.

## Timing
- Reset (`rst`=0 at a rising edge): state ENTER_A; all outputs 0, including `bcd_out`=0x00 and `digit_cnt`=0; timeout counter 0. Reset mid-operation aborts with no strobe on the following cycle.
- Key accepted at edge N → `bcd_out`/state updated after edge N, visible in cycle N+1.
- ENTER in ENTER_A at edge N: `load_a` high in cycle N+1 only; `bcd_out`=0x00 in cycle N+2.
- ENTER in ENTER_B at edge N: `load_b` in cycle N+1, `op_start` in N+2, WAIT_DONE from N+3.
- `op_done` at edge M → `disp_result`=1 in cycle M+1.
- Minimum ENTER-to-`op_start` latency: 2 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package `calc_pkg`: state enum `seq_state_t`; key constants `KEY_ENTER`=4'hA, `KEY_CLEAR`=4'hB; BCD digit typedef `bcd_digit_t` (4 bits).
- Sub-module `op_timeout_counter`:
  - Parameters: `TIMEOUT_CYCLES`.
  - Ports: `clk`, `rst`, `clear`, `enable`, `expired`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- The rest is a single FSM + datapath register block.

## Test plan
- Keys 4, 2, ENTER, 7, ENTER; `op_done` 5 cycles after `op_start` → `load_a` pulse with `bcd_out`=0x42; `load_b` pulse with 0x07; one `op_start`; SHOW with `error`=0.
- Keys 1, 2, 3, ENTER → `load_a` with `bcd_out`=0x23, `digit_cnt`=2.
- ENTER with no digits in ENTER_A → `load_a` with 0x00; then 9, CLEAR → ENTER_A, `bcd_out`=0x00, no `load_b`.
- `TIMEOUT_CYCLES`=8, no `op_done` → SHOW with `error`=1 exactly 8 cycles after entering WAIT_DONE; `op_done` coincident with expiry → `error`=0.
- `rst`=0 asserted during WAIT_DONE and during LOAD_B → next cycle all outputs 0, state ENTER_A, no `op_start`.
- Keys 0xC–0xF and digits during WAIT_DONE/SHOW → no change to `bcd_out`, `digit_cnt`, or state.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator operand sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        LOAD_A,
        ENTER_B,
        LOAD_B,
        START,
        WAIT_DONE,
        SHOW
    } seq_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t KEY_ENTER = 4'hA;
    localparam bcd_digit_t KEY_CLEAR = 4'hB;
    localparam bcd_digit_t KEY_DMAX  = 4'h9;

    function automatic logic is_digit(bcd_digit_t k);
        return k <= KEY_DMAX;
    endfunction

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// Keypad, arithmetic-unit and operand-register signals of the sequencer.
interface calc_operand_sequencer_if;
    import calc_pkg::*;

    logic       key_valid;
    bcd_digit_t key_code;
    logic       op_done;
    logic [7:0] bcd_out;
    logic [1:0] digit_cnt;
    logic       load_a;
    logic       load_b;
    logic       op_start;
    logic       busy;
    logic       disp_result;
    logic       error;

    modport master (
        output key_valid, key_code, op_done,
        input  bcd_out, digit_cnt, load_a, load_b,
        input  op_start, busy, disp_result, error
    );

    modport slave (
        input  key_valid, key_code, op_done,
        output bcd_out, digit_cnt, load_a, load_b,
        output op_start, busy, disp_result, error
    );

endinterface

// File: rtl/op_timeout_counter.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES enabled cycles.
module op_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Holds at LAST so a stalled enable never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/calc_operand_sequencer.sv
// Two-operand entry sequencer: digit assembly, load/start strobes, timeout.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    calc_operand_sequencer_if.slave bus
);

    seq_state_t state, state_n;
    logic [7:0] bcd, bcd_n;
    logic [1:0] cnt, cnt_n;
    logic       err, err_n;
    logic       expired;
    logic       key_dig, key_ent, key_clr;

    assign key_dig = bus.key_valid && is_digit(bus.key_code);
    assign key_ent = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign key_clr = bus.key_valid && (bus.key_code == KEY_CLEAR);

    op_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == START),
        .enable (state == WAIT_DONE),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ENTER_A;
            bcd   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            bcd   <= bcd_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        bcd_n   = bcd;
        cnt_n   = cnt;
        err_n   = err;
        if (key_clr) begin
            state_n = ENTER_A;
            bcd_n   = '0;
            cnt_n   = '0;
            err_n   = 1'b0;
        end else begin
            unique case (state)
                ENTER_A, ENTER_B: begin
                    if (key_dig) begin
                        bcd_n = {bcd[3:0], bus.key_code};
                        cnt_n = (cnt == 2'd2) ? cnt : cnt + 2'd1;
                    end else if (key_ent) begin
                        state_n = (state == ENTER_A) ? LOAD_A : LOAD_B;
                    end
                end
                LOAD_A: begin
                    state_n = ENTER_B;
                    bcd_n   = '0;
                    cnt_n   = '0;
                end
                LOAD_B: begin
                    state_n = START;
                    bcd_n   = '0;
                    cnt_n   = '0;
                end
                START: state_n = WAIT_DONE;
                WAIT_DONE: begin
                    // Completion beats a coincident timeout.
                    if (bus.op_done) begin
                        state_n = SHOW;
                        err_n   = 1'b0;
                    end else if (expired) begin
                        state_n = SHOW;
                        err_n   = 1'b1;
                    end
                end
                SHOW: begin
                    if (key_ent) begin
                        state_n = ENTER_A;
                        bcd_n   = '0;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                    end
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    assign bus.bcd_out     = bcd;
    assign bus.digit_cnt   = cnt;
    assign bus.load_a      = (state == LOAD_A);
    assign bus.load_b      = (state == LOAD_B);
    assign bus.op_start    = (state == START);
    assign bus.busy        = (state == START) || (state == WAIT_DONE);
    assign bus.disp_result = (state == SHOW);
    assign bus.error       = err;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed plus random bench for calc_operand_sequencer against a queue model.
module tb_calc_operand_sequencer;

    localparam int TO = 8;
    localparam logic [3:0] K_ENT = 4'hA;
    localparam logic [3:0] K_CLR = 4'hB;
    localparam int P_A  = 0;
    localparam int P_LA = 1;
    localparam int P_B  = 2;
    localparam int P_LB = 3;
    localparam int P_ST = 4;
    localparam int P_W  = 5;
    localparam int P_SH = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_operand_sequencer_if bus();

    calc_operand_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;

    int   m_phase = P_A;
    int   m_q[$];
    int   m_wait = 0;
    logic m_err = 1'b0;

    function automatic logic [7:0] m_bcd();
        int n;
        int v;
        n = m_q.size();
        v = 0;
        if (n >= 2) v = m_q[n-2] * 16;
        if (n >= 1) v = v + m_q[n-1];
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model(input logic kv, input logic [3:0] kc,
                         input logic dn, input logic r);
        if (!r) begin
            m_phase = P_A;
            m_q.delete();
            m_wait = 0;
            m_err = 1'b0;
        end else if (kv && kc == K_CLR) begin
            m_phase = P_A;
            m_q.delete();
            m_err = 1'b0;
        end else begin
            case (m_phase)
                P_A, P_B: begin
                    if (kv && kc <= 4'h9) begin
                        m_q.push_back(int'(kc));
                        if (m_q.size() > 2) void'(m_q.pop_front());
                    end else if (kv && kc == K_ENT) begin
                        m_phase = m_phase + 1;
                    end
                end
                P_LA: begin m_phase = P_B; m_q.delete(); end
                P_LB: begin m_phase = P_ST; m_q.delete(); end
                P_ST: begin m_phase = P_W; m_wait = 0; end
                P_W: begin
                    m_wait++;
                    if (dn) begin
                        m_phase = P_SH;
                        m_err = 1'b0;
                    end else if (m_wait == TO) begin
                        m_phase = P_SH;
                        m_err = 1'b1;
                    end
                end
                P_SH: begin
                    if (kv && kc == K_ENT) begin
                        m_phase = P_A;
                        m_q.delete();
                        m_err = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("bcd_out", bus.bcd_out, m_bcd());
        chk("digit_cnt", {6'b0, bus.digit_cnt}, 8'(m_q.size()));
        chk1("load_a", bus.load_a, m_phase == P_LA);
        chk1("load_b", bus.load_b, m_phase == P_LB);
        chk1("op_start", bus.op_start, m_phase == P_ST);
        chk1("busy", bus.busy, m_phase == P_ST || m_phase == P_W);
        chk1("disp_result", bus.disp_result, m_phase == P_SH);
        chk1("error", bus.error, m_err);
        if (bus.op_start === 1'b1) n_start++;
    endtask

    task automatic step(input logic kv, input logic [3:0] kc,
                        input logic dn, input logic r);
        @(negedge clk);
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.op_done   = dn;
        rst           = r;
        @(posedge clk);
        model(kv, kc, dn, r);
        #1;
        check_all();
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic done();
        step(1'b0, 4'h0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.op_done   = 1'b0;

        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst_bcd", bus.bcd_out, 8'h00);

        key(4'h4); key(4'h2); key(K_ENT);
        chk("p1_load_a_bcd", bus.bcd_out, 8'h42);
        chk1("p1_load_a", bus.load_a, 1'b1);
        idle(1);
        chk("p1_cleared", bus.bcd_out, 8'h00);
        key(4'h7); key(K_ENT);
        chk("p1_load_b_bcd", bus.bcd_out, 8'h07);
        n_start = 0;
        idle(5);
        done();
        chk("p1_one_start", 8'(n_start), 8'd1);
        chk1("p1_show", bus.disp_result, 1'b1);
        chk1("p1_no_err", bus.error, 1'b0);

        key(4'h5); key(4'hC); idle(1);
        chk("p6_show_bcd", bus.bcd_out, 8'h00);
        key(K_ENT);
        key(4'h1); key(4'h2); key(4'h3); key(K_ENT);
        chk("p2_bcd", bus.bcd_out, 8'h23);
        chk("p2_cnt", {6'b0, bus.digit_cnt}, 8'd2);

        key(K_CLR); key(K_ENT);
        chk1("p3_load_a", bus.load_a, 1'b1);
        chk("p3_bcd", bus.bcd_out, 8'h00);
        idle(1); key(4'h9); key(K_CLR);
        chk("p3_clr_bcd", bus.bcd_out, 8'h00);
        idle(1);
        chk1("p3_no_load_b", bus.load_b, 1'b0);

        key(4'h6); key(4'hD); key(4'hE); key(4'hF);
        chk("p6_ign_bcd", bus.bcd_out, 8'h06);

        key(K_ENT); idle(1); key(K_ENT); idle(2);
        idle(7);
        chk1("p4_still_busy", bus.busy, 1'b1);
        idle(1);
        chk1("p4_tmo_show", bus.disp_result, 1'b1);
        chk1("p4_tmo_err", bus.error, 1'b1);
        key(4'h3);
        chk("p6_wait_dig", bus.bcd_out, 8'h00);

        key(K_ENT); key(K_ENT); idle(1); key(K_ENT); idle(2);
        idle(7); done();
        chk1("p4_coinc_show", bus.disp_result, 1'b1);
        chk1("p4_coinc_err", bus.error, 1'b0);

        key(K_ENT); key(K_ENT); idle(1); key(K_ENT); idle(3);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk1("p5_wait_rst", bus.busy, 1'b0);
        key(4'h8); key(K_ENT); idle(1); key(K_ENT);
        chk1("p5_in_lb", bus.load_b, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk1("p5_lb_rst_start", bus.op_start, 1'b0);
        idle(1);
        chk1("p5_no_start", bus.op_start, 1'b0);

        for (int i = 0; i < 800; i++) begin
            logic kv;
            logic [3:0] kc;
            logic dn;
            logic r;
            kv = ($urandom_range(0, 2) == 0);
            kc = 4'($urandom_range(0, 15));
            if (kc == K_CLR && $urandom_range(0, 2) != 0) kc = K_ENT;
            dn = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 99) != 0);
            step(kv, kc, dn, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
